// File: rtl/bus_bridge_pkg.sv
// Shared definitions for the serial-to-bus bridge.
//   state_e    : bridge FSM state encoding
//   OP_*       : frame opcodes
//   RSP_*      : single-byte response codes
package bus_bridge_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StAddr  = 3'd1,
    StData  = 3'd2,
    StWrite = 3'd3,
    StRead  = 3'd4,
    StResp  = 3'd5,
    StErr   = 3'd6
  } state_e;

  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_WRITE = 8'h57;

  localparam logic [7:0] RSP_ACK  = 8'h4B;
  localparam logic [7:0] RSP_ERR  = 8'h45;

  // True for either accepted opcode.
  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OP_READ) || (b == OP_WRITE);
  endfunction

endpackage

// File: rtl/bridge_tx_shift.sv
// Response byte serializer for the bridge.
// Loads either 1 byte (taken from i_data[31:24]) or 4 bytes, and sends them MSB first
// over a valid/ready handshake. The loaded word doubles as the response register.
// Ports:
//   i_clk, i_reset    : clock, asynchronous active-high reset
//   i_load            : load i_data (takes priority over a handshake)
//   i_four            : 1 = four bytes, 0 = one byte
//   i_data            : word to send
//   o_tx_data/o_tx_valid/i_tx_ready : byte stream to the transmitter
//   o_done            : handshake on the last byte occurs this cycle
module bridge_tx_shift (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic        i_four,
  input  logic [31:0] i_data,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_done
);

  logic [31:0] r_shift;
  logic [2:0]  r_left;
  logic        r_valid;
  logic        w_fire;

  assign w_fire     = r_valid & i_tx_ready;
  assign o_done     = w_fire && (r_left == 3'd1);
  assign o_tx_data  = r_shift[31:24];
  assign o_tx_valid = r_valid;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_shift <= 32'h0;
      r_left  <= 3'd0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_shift <= i_data;
      r_left  <= i_four ? 3'd4 : 3'd1;
      r_valid <= 1'b1;
    end else if (w_fire) begin
      if (r_left == 3'd1) begin
        // Keep the last byte on o_tx_data; only valid drops.
        r_left  <= 3'd0;
        r_valid <= 1'b0;
      end else begin
        r_shift <= {r_shift[23:0], 8'h00};
        r_left  <= r_left - 3'd1;
      end
    end
  end

endmodule

// File: rtl/bus_bridge.sv
// Serial command bridge: turns byte frames into single 32-bit bus reads/writes.
//   Read frame : 52 A3 A2 A1 A0          -> response rdata, 4 bytes MSB first
//   Write frame: 57 A3 A2 A1 A0 D3..D0   -> response 4B
//   Bad opcode :                         -> response 45
// Optional feature macro BRIDGE_TIMEOUT_EN: drops a partial frame after TIMEOUT_CYCLES idle
// clocks in ADDR/DATA and pulses o_abort. Without it o_abort is tied low.
// Ports:
//   i_clk, i_reset              : clock, asynchronous active-high reset
//   i_rx_data/i_rx_valid/o_rx_ready : command byte stream in
//   o_tx_data/o_tx_valid/i_tx_ready : response byte stream out
//   o_rd, o_wr, o_addr, o_wdata, i_rdata : bus side (rdata combinational during o_rd)
//   o_busy                      : state is not idle
//   o_abort                     : one-cycle pulse when a frame is dropped
module bus_bridge
  import bus_bridge_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_rd,
  output logic        o_wr,
  output logic [31:0] o_addr,
  output logic [31:0] o_wdata,
  input  logic [31:0] i_rdata,
  output logic        o_busy,
  output logic        o_abort
);

  state_e      r_state;
  logic        r_op_write;
  logic [1:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_rd;
  logic        r_wr;

  logic        w_rx_fire;
  logic        w_tx_done;
  logic        w_load;
  logic        w_load_four;
  logic [31:0] w_load_data;

  assign o_rx_ready = (r_state == StIdle) || (r_state == StAddr) || (r_state == StData);
  assign w_rx_fire  = i_rx_valid & o_rx_ready;
  assign o_busy     = (r_state != StIdle);
  assign o_rd       = r_rd;
  assign o_wr       = r_wr;
  assign o_addr     = r_addr;
  assign o_wdata    = r_wdata;

`ifdef BRIDGE_TIMEOUT_EN
  logic [15:0] r_tmo;
  logic        r_abort;
  assign o_abort = r_abort;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign o_abort = 1'b0;
`endif

  // Serializer load requests. The read data is captured at the end of the rd cycle.
  always_comb begin
    w_load      = 1'b0;
    w_load_four = 1'b0;
    w_load_data = 32'h0;
    if (r_state == StWrite) begin
      w_load      = 1'b1;
      w_load_data = {RSP_ACK, 24'h0};
    end else if (r_state == StRead) begin
      w_load      = 1'b1;
      w_load_four = 1'b1;
      w_load_data = i_rdata;
    end else if ((r_state == StIdle) && w_rx_fire && !is_opcode(i_rx_data)) begin
      w_load      = 1'b1;
      w_load_data = {RSP_ERR, 24'h0};
    end
  end

  bridge_tx_shift u_tx_shift (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_load),
    .i_four     (w_load_four),
    .i_data     (w_load_data),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .o_done     (w_tx_done)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_op_write <= 1'b0;
      r_cnt      <= 2'd0;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
      r_tmo      <= 16'd0;
      r_abort    <= 1'b0;
`endif
    end else begin
      // Strobes are set on entry to READ/WRITE and last exactly one cycle.
      r_rd <= 1'b0;
      r_wr <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_rx_fire) begin
            if (is_opcode(i_rx_data)) begin
              r_op_write <= (i_rx_data == OP_WRITE);
              r_cnt      <= 2'd0;
              r_state    <= StAddr;
            end else begin
              r_state <= StErr;
            end
          end
        end
        StAddr: begin
          if (w_rx_fire) begin
            r_addr <= {r_addr[23:0], i_rx_data};
            r_cnt  <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              if (r_op_write) begin
                r_state <= StData;
              end else begin
                r_state <= StRead;
                r_rd    <= 1'b1;
              end
            end
          end
        end
        StData: begin
          if (w_rx_fire) begin
            r_wdata <= {r_wdata[23:0], i_rx_data};
            r_cnt   <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_state <= StWrite;
              r_wr    <= 1'b1;
            end
          end
        end
        StWrite, StRead: r_state <= StResp;
        StResp, StErr: begin
          if (w_tx_done) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase

`ifdef BRIDGE_TIMEOUT_EN
      // Idle-gap watchdog inside a frame; overrides the state update above.
      r_abort <= 1'b0;
      if (((r_state == StAddr) || (r_state == StData)) && !w_rx_fire) begin
        if (r_tmo == 16'(TIMEOUT_CYCLES - 16'd1)) begin
          r_abort <= 1'b1;
          r_state <= StIdle;
          r_cnt   <= 2'd0;
          r_tmo   <= 16'd0;
        end else begin
          r_tmo <= r_tmo + 16'd1;
        end
      end else begin
        r_tmo <= 16'd0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_bus_bridge.sv
// Directed self-checking bench for bus_bridge (TIMEOUT_CYCLES = 20).
module tb_bus_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        rd, wr, busy, abort;
  logic [31:0] addr, wdata, rdata;
  logic [31:0] rdata_val = 32'h0;

  // Read data is only meaningful while rd is high.
  assign rdata = rd ? rdata_val : 32'hFFFF_FFFF;

  always #5 clk = ~clk;

  bus_bridge #(.TIMEOUT_CYCLES(16'd20)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .o_rx_ready (rx_ready),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .i_tx_ready (tx_ready),
    .o_rd       (rd),
    .o_wr       (wr),
    .o_addr     (addr),
    .o_wdata    (wdata),
    .i_rdata    (rdata),
    .o_busy     (busy),
    .o_abort    (abort)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Bus/response monitor, sampled mid-cycle.
  int          wr_cnt = 0, rd_cnt = 0, both_cnt = 0, abort_cnt = 0;
  logic [31:0] wr_addr = 32'h0, wr_data = 32'h0, rd_addr = 32'h0;
  logic [7:0]  tx_q[$];

  always @(negedge clk) begin
    if (wr) begin wr_cnt++; wr_addr = addr; wr_data = wdata; end
    if (rd) begin rd_cnt++; rd_addr = addr; end
    if (rd && wr) both_cnt++;
    if (abort) abort_cnt++;
    if (tx_valid && tx_ready && !reset) tx_q.push_back(tx_data);
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("rx_stall", {31'h0, rx_ready}, 32'h1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin @(negedge clk); n++; end
    check(tag, {31'h0, busy}, 32'h0);
  endtask

  task automatic send_read(input logic [31:0] a);
    send_byte(8'h52);
    for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
  endtask

  int          wr0, rd0;
  logic [7:0]  first;
  logic        stable;

  initial begin
    // Reset state.
    #12;
    @(negedge clk);
    check("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
    check("rst_busy",     {31'h0, busy},     32'h0);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_strobes",  {30'h0, rd, wr},   32'h0);
    check("rst_abort",    {31'h0, abort},    32'h0);
    check("rst_addr",     addr,              32'h0);
    check("rst_wdata",    wdata,             32'h0);
    check("rst_tx_data",  {24'h0, tx_data},  32'h0);
    reset = 1'b0;

    // Write frame.
    tx_q.delete();
    send_byte(8'h57);
    send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h0C);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'hA5);
    wait_idle("wr_idle");
    check("wr_pulses",   wr_cnt,  32'd1);
    check("wr_addr",     wr_addr, 32'h4000_000C);
    check("wr_wdata",    wr_data, 32'h0000_00A5);
    check("wr_no_rd",    rd_cnt,  32'd0);
    check("wr_tx_count", tx_q.size(), 32'd1);
    if (tx_q.size() > 0) check("wr_tx_byte", {24'h0, tx_q[0]}, 32'h4B);
    check("wr_tx_drop",  {31'h0, tx_valid}, 32'h0);
    check("wr_addr_hold",  addr,  32'h4000_000C);
    check("wr_wdata_hold", wdata, 32'h0000_00A5);

    // Read frame.
    tx_q.delete();
    rdata_val = 32'h0000_003C;
    send_read(32'h4000_0010);
    wait_idle("rd_idle");
    check("rd_pulses",   rd_cnt,  32'd1);
    check("rd_addr",     rd_addr, 32'h4000_0010);
    check("rd_no_wr",    wr_cnt,  32'd1);
    check("rd_tx_count", tx_q.size(), 32'd4);
    if (tx_q.size() == 4)
      check("rd_tx_bytes", {tx_q[0], tx_q[1], tx_q[2], tx_q[3]}, 32'h0000_003C);
    check("rd_wdata_hold", wdata, 32'h0000_00A5);

    // Bad opcode.
    tx_q.delete();
    wr0 = wr_cnt; rd0 = rd_cnt;
    send_byte(8'h11);
    wait_idle("err_idle");
    check("err_tx_count", tx_q.size(), 32'd1);
    if (tx_q.size() > 0) check("err_tx_byte", {24'h0, tx_q[0]}, 32'h45);
    check("err_no_bus", wr_cnt + rd_cnt, wr0 + rd0);

    // Partial frame followed by a 25-cycle gap.
    tx_q.delete();
    wr0 = wr_cnt;
    send_byte(8'h57);
    send_byte(8'h40);
    repeat (25) @(negedge clk);
`ifdef BRIDGE_TIMEOUT_EN
    check("tmo_abort",  abort_cnt,   32'd1);
    check("tmo_idle",   {31'h0, busy}, 32'h0);
    check("tmo_no_wr",  wr_cnt,      wr0);
    check("tmo_no_tx",  tx_q.size(), 32'd0);
`else
    check("notmo_abort", abort_cnt,     32'd0);
    check("notmo_busy",  {31'h0, busy}, 32'h1);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h0C);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    wait_idle("notmo_idle");
    check("notmo_wr",    wr_cnt,  wr0 + 1);
    check("notmo_addr",  wr_addr, 32'h4000_000C);
    check("notmo_wdata", wr_data, 32'h1122_3344);
    check("notmo_tx",    tx_q.size(), 32'd1);
`endif

    // Reset during the third data byte of a write.
    tx_q.delete();
    wr0 = wr_cnt;
    send_byte(8'h57);
    send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h0C);
    send_byte(8'h00); send_byte(8'h00);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h00;
    #2 reset = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", {31'h0, busy}, 32'h0);
    rx_valid = 1'b0;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_mid_no_wr", wr_cnt, wr0);
    check("rst_mid_no_tx", tx_q.size(), 32'd0);
    rd0 = rd_cnt;
    send_read(32'h4000_0010);
    wait_idle("rst_rd_idle");
    check("rst_rd_pulses", rd_cnt, rd0 + 1);
    check("rst_rd_addr",   rd_addr, 32'h4000_0010);
    if (tx_q.size() == 4)
      check("rst_rd_bytes", {tx_q[0], tx_q[1], tx_q[2], tx_q[3]}, 32'h0000_003C);
    else
      check("rst_rd_count", tx_q.size(), 32'd4);

    // Transmitter back-pressure.
    tx_q.delete();
    rdata_val = 32'h1122_3344;
    tx_ready = 1'b0;
    send_read(32'h0000_0020);
    for (int n = 0; n < 20 && !tx_valid; n++) @(negedge clk);
    check("bp_valid", {31'h0, tx_valid}, 32'h1);
    first  = tx_data;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (tx_data !== first || tx_valid !== 1'b1) stable = 1'b0;
    end
    check("bp_stable", {31'h0, stable}, 32'h1);
    check("bp_first",  {24'h0, first},  32'h11);
    @(posedge clk);
    #1 tx_ready = 1'b1;
    wait_idle("bp_idle");
    check("bp_tx_count", tx_q.size(), 32'd4);
    if (tx_q.size() == 4)
      check("bp_tx_bytes", {tx_q[0], tx_q[1], tx_q[2], tx_q[3]}, 32'h1122_3344);

    check("rd_wr_overlap", both_cnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
